// File: rtl/imm_encoder_pkg.sv
// imm_encoder_pkg: definitions shared by the immediate encoder, the core's
// decoder/control unit and the assembler model.
//   imm_type_e     - immediate format codes (101..111 are handled as I)
//   ERRCNT_W       - width of the saturating error counter
//   upper_uniform  - true when all bits selected by a mask hold the same value
package imm_encoder_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_U = 3'b001,
    IMM_S = 3'b010,
    IMM_J = 3'b011,
    IMM_B = 3'b100
  } imm_type_e;

  localparam int ERRCNT_W = 16;

  // Masks covering the bits that must all equal the sign bit for each format.
  localparam logic [31:0] RANGE_MASK_IS = 32'hFFFF_F800;  // imm[31:11]
  localparam logic [31:0] RANGE_MASK_B  = 32'hFFFF_F000;  // imm[31:12]
  localparam logic [31:0] RANGE_MASK_J  = 32'hFFF0_0000;  // imm[31:20]

  // A sign-extended value has every masked bit equal: all zero or all one.
  function automatic logic upper_uniform(input logic [31:0] value,
                                         input logic [31:0] mask);
    logic [31:0] sel;
    sel = value & mask;
    return (sel == 32'h0000_0000) || (sel == mask);
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// imm_encoder_if: the encoder's input stream, output stream and status.
//   slave  - encoder view (consumes input beats, produces output beats)
//   master - host/loader view (drives input beats, accepts output beats)
// Input beat : in_valid/in_ready, in_imm_type, in_imm, in_template
// Output beat: out_valid/out_ready, out_instr, out_addr, out_err
// Status     : err_count
interface imm_encoder_if #(
  parameter int ADDR_W = 10
);
  import imm_encoder_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [2:0]          in_imm_type;
  logic [31:0]         in_imm;
  logic [31:0]         in_template;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_instr;
  logic [ADDR_W-1:0]   out_addr;
  logic                out_err;
  logic [ERRCNT_W-1:0] err_count;

  modport slave (
    input  in_valid, in_imm_type, in_imm, in_template, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err, err_count
  );

  modport master (
    output in_valid, in_imm_type, in_imm, in_template, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err, err_count
  );

endinterface

// File: rtl/imm_encoder_scatter.sv
// imm_scatter: combinational immediate scatter and range check.
//   type_i  - format code (unknown codes behave as I)
//   imm_i   - immediate value
//   tmpl_i  - instruction template; immediate fields are overwritten
//   instr_o - template with the immediate scattered in (truncated if err_o)
//   err_o   - immediate not representable in the selected format
module imm_scatter
  import imm_encoder_pkg::*;
(
  input  logic [2:0]  type_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] tmpl_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

  // Select the bit layout and representability rule for the format.
  always_comb begin
    instr_o = tmpl_i;
    err_o   = 1'b0;
    case (type_i)
      IMM_U: begin
        instr_o[31:12] = imm_i[31:12];
        err_o          = (imm_i[11:0] != 12'h000);
      end
      IMM_S: begin
        instr_o[31:25] = imm_i[11:5];
        instr_o[11:7]  = imm_i[4:0];
        err_o          = !upper_uniform(imm_i, RANGE_MASK_IS);
      end
      IMM_B: begin
        instr_o[31]    = imm_i[12];
        instr_o[30:25] = imm_i[10:5];
        instr_o[11:8]  = imm_i[4:1];
        instr_o[7]     = imm_i[11];
        // Branch offsets are halfword aligned; bit 0 has no encoding.
        err_o          = !upper_uniform(imm_i, RANGE_MASK_B) || imm_i[0];
      end
      IMM_J: begin
        instr_o[31]    = imm_i[20];
        instr_o[30:21] = imm_i[10:1];
        instr_o[20]    = imm_i[11];
        instr_o[19:12] = imm_i[19:12];
        err_o          = !upper_uniform(imm_i, RANGE_MASK_J) || imm_i[0];
      end
      default: begin
        // I format, also used for the unassigned codes 101..111.
        instr_o[31:20] = imm_i[11:0];
        err_o          = !upper_uniform(imm_i, RANGE_MASK_IS);
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage pipelined immediate encoder for the program loader.
//   clk, reset - clock and asynchronous active-high reset
//   bus        - imm_encoder_if slave: input beats in, encoded words out,
//                plus the saturating error counter
// S1 registers the raw beat, imm_scatter encodes between S1 and S2, S2 drives
// the output. Each output transfer takes the next sequential word address.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic           clk,
  input  logic           reset,
  imm_encoder_if.slave   bus
);

  logic                s2_adv, s1_adv, xfer;
  logic                s1_valid_q, s1_valid_d;
  logic [2:0]          s1_type_q, s1_type_d;
  logic [31:0]         s1_imm_q, s1_imm_d;
  logic [31:0]         s1_tmpl_q, s1_tmpl_d;
  logic                s2_valid_q, s2_valid_d;
  logic [31:0]         instr_q, instr_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;
  logic [31:0]         enc_instr;
  logic                enc_err;

  imm_scatter u_scatter (
    .type_i  (s1_type_q),
    .imm_i   (s1_imm_q),
    .tmpl_i  (s1_tmpl_q),
    .instr_o (enc_instr),
    .err_o   (enc_err)
  );

  // Stage advance conditions; in_ready follows out_ready combinationally.
  always_comb begin
    s2_adv = !s2_valid_q || bus.out_ready;
    s1_adv = !s1_valid_q || s2_adv;
    xfer   = s2_valid_q && bus.out_ready;
  end

  // Next state for both stages, the address counter and the error counter.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_type_d   = s1_type_q;
    s1_imm_d    = s1_imm_q;
    s1_tmpl_d   = s1_tmpl_q;
    s2_valid_d  = s2_valid_q;
    instr_d     = instr_q;
    err_d       = err_q;
    addr_d      = addr_q;
    err_count_d = err_count_q;

    if (s1_adv && bus.in_valid) begin
      s1_valid_d = 1'b1;
      s1_type_d  = bus.in_imm_type;
      s1_imm_d   = bus.in_imm;
      s1_tmpl_d  = bus.in_template;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    // Data only loads from a valid S1 so an idle S2 keeps its last word.
    if (s2_adv && s1_valid_q) begin
      s2_valid_d = 1'b1;
      instr_d    = enc_instr;
      err_d      = enc_err;
    end else if (s2_adv) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end

    if (xfer) begin
      addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      if (err_q && (err_count_q != {ERRCNT_W{1'b1}})) begin
        err_count_d = err_count_q + {{(ERRCNT_W-1){1'b0}}, 1'b1};
      end else begin
        err_count_d = err_count_q;
      end
    end else begin
      addr_d = addr_q;
    end
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_type_q   <= 3'b000;
      s1_imm_q    <= 32'h0000_0000;
      s1_tmpl_q   <= 32'h0000_0000;
      s2_valid_q  <= 1'b0;
      instr_q     <= 32'h0000_0000;
      err_q       <= 1'b0;
      addr_q      <= BASE_ADDR;
      err_count_q <= {ERRCNT_W{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_type_q   <= s1_type_d;
      s1_imm_q    <= s1_imm_d;
      s1_tmpl_q   <= s1_tmpl_d;
      s2_valid_q  <= s2_valid_d;
      instr_q     <= instr_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_instr = instr_q;
  assign bus.out_err   = err_q;
  assign bus.out_addr  = addr_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed format vectors, latency,
// backpressure, mid-stream reset and a long randomized run, all outputs
// checked against a scoreboard filled from an independent encoder model.
module tb_imm_encoder;

  localparam int          AW      = 10;
  localparam logic [9:0]  TB_BASE = 10'h3FC;  // near the top so the address wraps
  localparam logic [2:0]  T_I = 3'b000, T_U = 3'b001, T_S = 3'b010,
                          T_J = 3'b011, T_B = 3'b100;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [31:0] imm;
    logic [2:0]  t;
  } sb_t;

  logic clk;
  logic reset;
  imm_encoder_if #(.ADDR_W(AW)) bus ();

  imm_encoder #(.ADDR_W(AW), .BASE_ADDR(TB_BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  sb_t         sb[$];
  logic [9:0]  exp_addr;
  logic [15:0] exp_errcnt;
  int          total = 0;
  int          bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

  // Reference encoder, written from the format tables: {err, instr}.
  function automatic logic [32:0] model_enc(input logic [2:0] t, input logic [31:0] imm,
                                            input logic [31:0] tmpl);
    int   s;
    logic e;
    logic [31:0] w;
    s = $signed(imm);
    case (t)
      T_U: begin w = {imm[31:12], tmpl[11:0]}; e = (imm[11:0] != 12'd0); end
      T_S: begin
        w = {imm[11:5], tmpl[24:12], imm[4:0], tmpl[6:0]};
        e = (s < -2048) || (s > 2047);
      end
      T_B: begin
        w = {imm[12], imm[10:5], tmpl[24:12], imm[4:1], imm[11], tmpl[6:0]};
        e = (s < -4096) || (s > 4095) || imm[0];
      end
      T_J: begin
        w = {imm[20], imm[10:1], imm[11], imm[19:12], tmpl[11:0]};
        e = (s < -1048576) || (s > 1048575) || imm[0];
      end
      default: begin w = {imm[11:0], tmpl[19:0]}; e = (s < -2048) || (s > 2047); end
    endcase
    return {e, w};
  endfunction

  // Immediate decoder as the core's immediate generator would do it.
  function automatic logic [31:0] decode(input logic [2:0] t, input logic [31:0] i);
    case (t)
      T_U:     return {i[31:12], 12'h000};
      T_S:     return {{20{i[31]}}, i[31:25], i[11:7]};
      T_B:     return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      T_J:     return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

  task automatic model_clear();
    sb.delete();
    exp_addr   = TB_BASE;
    exp_errcnt = 16'd0;
  endtask

  // One clock cycle: drive, score any output transfer, record any accept.
  task automatic cycle(input logic v, input logic [2:0] t, input logic [31:0] imm,
                       input logic [31:0] tmpl, input logic ordy, output logic acc);
    sb_t         e;
    logic [32:0] m;
    bus.in_valid    = v;
    bus.in_imm_type = t;
    bus.in_imm      = imm;
    bus.in_template = tmpl;
    bus.out_ready   = ordy;
    #1;
    acc = v && bus.in_ready;
    if (bus.out_valid && ordy) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_extra: out_instr=%h with no beat outstanding", bus.out_instr);
      end else begin
        e = sb.pop_front();
        if (bus.out_instr !== e.instr || bus.out_err !== e.err || bus.out_addr !== exp_addr) begin
          bad++;
          $display("FAIL sb_beat: got instr=%h err=%b addr=%h, want instr=%h err=%b addr=%h",
                   bus.out_instr, bus.out_err, bus.out_addr, e.instr, e.err, exp_addr);
        end
        if (!e.err) begin
          total++;
          if (decode(e.t, bus.out_instr) !== e.imm) begin
            bad++;
            $display("FAIL roundtrip: type=%0d decoded=%h want=%h", e.t,
                     decode(e.t, bus.out_instr), e.imm);
          end
        end
        if (e.err && exp_errcnt != 16'hFFFF) exp_errcnt++;
        exp_addr++;
      end
    end
    if (acc) begin
      m = model_enc(t, imm, tmpl);
      sb.push_back('{instr: m[31:0], err: m[32], imm: imm, t: t});
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.err_count !== exp_errcnt) begin
      bad++;
      $display("FAIL err_count: got %0d want %0d", bus.err_count, exp_errcnt);
    end
  endtask

  task automatic drain();
    logic a;
    int   n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      cycle(1'b0, T_I, 32'd0, 32'd0, 1'b1, a);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d beats outstanding, want 0", sb.size());
    end
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_imm_type = 3'b000; bus.in_imm = 32'd0; bus.in_template = 32'd0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'd0 || bus.out_err !== 1'b0 ||
        bus.out_addr !== TB_BASE || bus.err_count !== 16'd0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: valid=%b instr=%h err=%b addr=%h cnt=%0d rdy=%b, want 0 0 0 %h 0 1",
               bus.out_valid, bus.out_instr, bus.out_err, bus.out_addr, bus.err_count,
               bus.in_ready, TB_BASE);
    end
  endtask

  task automatic test_i_latency();
    logic a;
    do_reset();
    cycle(1'b1, T_I, 32'hFFFF_FFFF, 32'h0000_0013, 1'b1, a);
    total++;
    if (!a || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL i_latency1: accepted=%b out_valid=%b, want 1 0", a, bus.out_valid);
    end
    cycle(1'b0, T_I, 32'd0, 32'd0, 1'b1, a);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hFFF0_0013 || bus.out_err !== 1'b0 ||
        bus.out_addr !== TB_BASE) begin
      bad++;
      $display("FAIL i_vector: valid=%b instr=%h err=%b addr=%h, want 1 fff00013 0 %h",
               bus.out_valid, bus.out_instr, bus.out_err, bus.out_addr, TB_BASE);
    end
    drain();
  endtask

  task automatic test_b_format();
    logic a;
    do_reset();
    cycle(1'b1, T_B, 32'h0000_0FFE, 32'h0000_0063, 1'b1, a);
    cycle(1'b1, T_B, 32'h0000_1001, 32'h0000_0063, 1'b1, a);
    total++;
    if (bus.out_instr !== 32'h7E00_0FE3 || bus.out_err !== 1'b0) begin
      bad++;
      $display("FAIL b_vector: instr=%h err=%b, want 7e000fe3 0", bus.out_instr, bus.out_err);
    end
    cycle(1'b0, T_I, 32'd0, 32'd0, 1'b1, a);
    total++;
    if (bus.out_err !== 1'b1) begin
      bad++;
      $display("FAIL b_error: err=%b, want 1", bus.out_err);
    end
    cycle(1'b0, T_I, 32'd0, 32'd0, 1'b1, a);
    total++;
    if (bus.err_count !== 16'd1) begin
      bad++;
      $display("FAIL b_errcount: got %0d want 1", bus.err_count);
    end
  endtask

  task automatic test_j_u_format();
    logic a;
    do_reset();
    cycle(1'b1, T_J, 32'h0000_0800, 32'h0000_006F, 1'b1, a);
    cycle(1'b1, T_U, 32'h1234_5000, 32'h0000_0037, 1'b1, a);
    total++;
    if (bus.out_instr !== 32'h0010_006F || bus.out_err !== 1'b0) begin
      bad++;
      $display("FAIL j_vector: instr=%h err=%b, want 0010006f 0", bus.out_instr, bus.out_err);
    end
    cycle(1'b1, T_U, 32'h1234_5001, 32'h0000_0037, 1'b1, a);
    total++;
    if (bus.out_instr !== 32'h1234_5037 || bus.out_err !== 1'b0) begin
      bad++;
      $display("FAIL u_vector: instr=%h err=%b, want 12345037 0", bus.out_instr, bus.out_err);
    end
    cycle(1'b0, T_I, 32'd0, 32'd0, 1'b1, a);
    total++;
    if (bus.out_err !== 1'b1) begin
      bad++;
      $display("FAIL u_error: err=%b, want 1", bus.out_err);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] imms[4];
    logic [31:0] held;
    logic        a;
    int          idx, n;
    imms = '{32'd1, 32'h0000_0FFF, 32'hFFFF_F800, 32'h0000_0800};
    do_reset();
    idx = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, T_S, imms[idx], 32'h0000_2023, 1'b0, a);
      if (a) idx++;
    end
    total++;
    if (idx != 2 || bus.in_ready !== 1'b0 || bus.out_addr !== TB_BASE) begin
      bad++;
      $display("FAIL bp_accept: accepted=%0d in_ready=%b addr=%h, want 2 0 %h",
               idx, bus.in_ready, bus.out_addr, TB_BASE);
    end
    held = bus.out_instr;
    cycle(1'b1, T_S, imms[idx], 32'h0000_2023, 1'b0, a);
    total++;
    if (a || bus.out_valid !== 1'b1 || bus.out_instr !== held) begin
      bad++;
      $display("FAIL bp_hold: accepted=%b valid=%b instr=%h, want 0 1 %h",
               a, bus.out_valid, bus.out_instr, held);
    end
    n = 0;
    while ((idx < 4 || sb.size() != 0) && n < 50) begin
      cycle(idx < 4, T_S, (idx < 4) ? imms[idx & 3] : 32'd0, 32'h0000_2023, 1'b1, a);
      if (a) idx++;
      n++;
    end
    total++;
    if (idx != 4 || exp_addr !== TB_BASE + 10'd4) begin
      bad++;
      $display("FAIL bp_release: beats=%0d next_addr=%h, want 4 %h", idx, exp_addr,
               TB_BASE + 10'd4);
    end
  endtask

  task automatic test_reset_midstream();
    logic a;
    do_reset();
    cycle(1'b1, T_B, 32'h0000_1001, 32'h0000_0063, 1'b1, a);
    drain();
    cycle(1'b1, T_I, 32'd5, 32'h0000_0013, 1'b0, a);
    cycle(1'b1, T_I, 32'd6, 32'h0000_0013, 1'b0, a);
    total++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.err_count !== 16'd1) begin
      bad++;
      $display("FAIL rst_full: valid=%b in_ready=%b cnt=%0d, want 1 0 1",
               bus.out_valid, bus.in_ready, bus.err_count);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_addr !== TB_BASE || bus.err_count !== 16'd0) begin
      bad++;
      $display("FAIL rst_async: valid=%b addr=%h cnt=%0d, want 0 %h 0",
               bus.out_valid, bus.out_addr, bus.err_count, TB_BASE);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    #1;
    cycle(1'b1, T_I, 32'd7, 32'h0000_0013, 1'b1, a);
    drain();
  endtask

  task automatic test_random();
    logic [2:0]  t;
    logic [31:0] imm, tmpl;
    logic        a;
    int          n, cyc, flagged, sel;
    do_reset();
    n = 0; cyc = 0; flagged = 0;
    t = 3'($urandom_range(0, 7)); imm = $urandom; tmpl = $urandom;
    while (n < 10000 && cyc < 40000) begin
      cycle($urandom_range(0, 9) != 0, t, imm, tmpl, $urandom_range(0, 3) != 0, a);
      cyc++;
      if (a) begin
        if (model_enc(t, imm, tmpl) >> 32) flagged++;
        n++;
        t    = 3'($urandom_range(0, 7));
        tmpl = $urandom;
        sel  = $urandom_range(0, 3);
        case (sel)
          0:       imm = $urandom;
          1:       imm = 32'($urandom_range(0, 10000)) - 32'd5000;
          2:       imm = $urandom & 32'hFFFF_F000;
          default: imm = (32'($urandom_range(0, 4194304)) - 32'd2097152) & 32'hFFFF_FFFE;
        endcase
      end
    end
    drain();
    total++;
    if (n != 10000 || bus.err_count !== 16'(flagged)) begin
      bad++;
      $display("FAIL random: beats=%0d err_count=%0d, want 10000 %0d", n, bus.err_count, flagged);
    end
  endtask

  initial begin
    reset = 1'b1;
    model_clear();
    test_reset();
    test_i_latency();
    test_b_format();
    test_j_u_format();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
